// File: rtl/line_sequencer_pkg.sv
// line_seq_pkg: shared state encoding, default geometry and coordinate type for the line sequencer
package line_seq_pkg;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int COORD_W_DEF = 11;
  typedef enum logic [1:0] {CLEAR, IDLE, ERASE, DRAW} seq_state_t;
  typedef logic [COORD_W_DEF-1:0] coord_t;
endpackage

// File: rtl/line_sequencer_if.sv
// line_sequencer_if: line-command handshake and clear request from the key/switch logic
interface line_sequencer_if import line_seq_pkg::*; #(parameter int COORD_W = COORD_W_DEF);
  logic cmd_valid;
  logic cmd_ready;
  logic clear_req;
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  modport master(output cmd_valid, clear_req, cmd_x0, cmd_y0, cmd_x1, cmd_y1, input cmd_ready);
  modport slave(input cmd_valid, clear_req, cmd_x0, cmd_y0, cmd_x1, cmd_y1, output cmd_ready);
endinterface

// File: rtl/line_sequencer_stepper.sv
// bresenham_stepper: integer Bresenham walker; x/y/valid/last describe the pixel taken at the next edge
module bresenham_stepper import line_seq_pkg::*; #(parameter int COORD_W = COORD_W_DEF) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic start,
  input  logic [COORD_W-1:0] x0, y0, x1, y1,
  output logic [COORD_W-1:0] x, y,
  output logic valid,
  output logic last
);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  logic [COORD_W-1:0] cx, cy, ex, ey, adx, ady, nx, ny;
  logic signed [COORD_W+1:0] dx, dy, err, e2, err_n, ldx, ldy;
  logic run, sx_neg, sy_neg, step_x, step_y, at_end;
  always_comb begin
    adx = x1 >= x0 ? x1 - x0 : x0 - x1;
    ady = y1 >= y0 ? y1 - y0 : y0 - y1;
    ldx = $signed({2'b00, adx});
    ldy = -$signed({2'b00, ady});
    e2 = err <<< 1;
    step_x = e2 >= dy;
    step_y = e2 <= dx;
    nx = step_x ? (sx_neg ? cx - ONE : cx + ONE) : cx;
    ny = step_y ? (sy_neg ? cy - ONE : cy + ONE) : cy;
    err_n = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    at_end = cx == ex && cy == ey;
    x = start ? x0 : nx;
    y = start ? y0 : ny;
    valid = start || (run && !at_end);
    last = valid && x == (start ? x1 : ex) && y == (start ? y1 : ey);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      run <= 1'b0;
    end else begin
      run <= valid;
      if (start) begin
        ex <= x1;
        ey <= y1;
        sx_neg <= x1 < x0;
        sy_neg <= y1 < y0;
        dx <= ldx;
        dy <= ldy;
        err <= ldx + ldy;
        cx <= x0;
        cy <= y0;
      end else if (valid) begin
        cx <= nx;
        cy <= ny;
        err <= err_n;
      end
    end
  end
endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: owns the framebuffer write port; clears the screen, erases the previous line, draws the new one
module line_sequencer import line_seq_pkg::*; #(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  line_sequencer_if.slave cmd,
  output logic busy,
  output logic done,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic fb_color,
  output logic fb_write
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  seq_state_t st, st_n;
  logic has_prev, fb_last, live, accept, clr_last, stp_start, stp_valid, stp_last;
  logic [COORD_W-1:0] px0, py0, px1, py1, cx0, cy0, cx1, cy1;
  logic [COORD_W-1:0] sx0, sy0, sx1, sy1, stp_x, stp_y;
  function automatic logic vis(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
    return px <= XMAX && py <= YMAX;
  endfunction
  // In IDLE the stepper is fed the erase line (or the new one when nothing is on screen);
  // the DRAW reload after an erase takes the latched command.
  always_comb begin
    accept = st == IDLE && cmd.cmd_valid && !cmd.clear_req;
    sx0 = st == IDLE ? (has_prev ? px0 : cmd.cmd_x0) : cx0;
    sy0 = st == IDLE ? (has_prev ? py0 : cmd.cmd_y0) : cy0;
    sx1 = st == IDLE ? (has_prev ? px1 : cmd.cmd_x1) : cx1;
    sy1 = st == IDLE ? (has_prev ? py1 : cmd.cmd_y1) : cy1;
    stp_start = accept || (st == DRAW && !live);
    clr_last = fb_write && fb_x == XMAX && fb_y == YMAX;
  end
  always_comb begin
    st_n = st;
    case (st)
      CLEAR: st_n = clr_last ? IDLE : CLEAR;
      IDLE: st_n = cmd.clear_req ? CLEAR : cmd.cmd_valid ? (has_prev ? ERASE : DRAW) : IDLE;
      ERASE: st_n = fb_last ? DRAW : ERASE;
      DRAW: st_n = fb_last ? IDLE : DRAW;
    endcase
  end
  always_ff @(posedge CLOCK_50) st <= reset ? CLEAR : st_n;
  bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .start(stp_start),
    .x0(sx0),
    .y0(sy0),
    .x1(sx1),
    .y1(sy1),
    .x(stp_x),
    .y(stp_y),
    .valid(stp_valid),
    .last(stp_last)
  );
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fb_x <= '0;
      fb_y <= '0;
      fb_color <= 1'b0;
      fb_write <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      has_prev <= 1'b0;
      fb_last <= 1'b0;
      live <= 1'b0;
    end else begin
      cmd.cmd_ready <= st_n == IDLE;
      busy <= st_n != IDLE;
      done <= st == DRAW && fb_last;
      fb_last <= stp_last;
      live <= stp_valid;
      if (st == CLEAR) begin
        fb_color <= 1'b0;
        fb_write <= !clr_last;
        if (fb_write && !clr_last) begin
          fb_x <= fb_x == XMAX ? '0 : fb_x + ONE;
          fb_y <= fb_x == XMAX ? fb_y + ONE : fb_y;
        end
      end else if (st == IDLE && cmd.clear_req) begin
        fb_x <= '0;
        fb_y <= '0;
        fb_color <= 1'b0;
        fb_write <= 1'b1;
        has_prev <= 1'b0;
      end else begin
        fb_x <= stp_x;
        fb_y <= stp_y;
        fb_color <= st_n == DRAW;
        fb_write <= stp_valid && vis(stp_x, stp_y);
      end
      if (accept) {cx0, cy0, cx1, cy1} <= {cmd.cmd_x0, cmd.cmd_y0, cmd.cmd_x1, cmd.cmd_y1};
      if (st == DRAW && fb_last) begin
        {px0, py0, px1, py1} <= {cx0, cy0, cx1, cy1};
        has_prev <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: scoreboard bench on a small screen; expected writes come from a pixel-list model of each command
module tb_line_sequencer;
  import line_seq_pkg::*;
  localparam int W = 16;
  localparam int H = 12;
  localparam int CW = 11;
  typedef struct {int c; int x; int y; int col;} wr_t;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic busy, done, fb_color, fb_write;
  logic [CW-1:0] fb_x, fb_y;
  wr_t wq[$], eq[$], mon_w;
  int dq[$], edq[$], lx[$], ly[$];
  int cyc = 0, total = 0, bad = 0, horizon = 0, last_done = 0, m_has_prev = 0;
  int mp[4];
  line_sequencer_if #(.COORD_W(CW)) cif();
  line_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .cmd(cif),
    .busy(busy),
    .done(done),
    .fb_x(fb_x),
    .fb_y(fb_y),
    .fb_color(fb_color),
    .fb_write(fb_write)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50) begin
    if (fb_write) begin
      mon_w.c = cyc;
      mon_w.x = int'(fb_x);
      mon_w.y = int'(fb_y);
      mon_w.col = int'(fb_color);
      wq.push_back(mon_w);
    end
    if (done) dq.push_back(cyc);
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // Pixel list of a line, straight from the integer Bresenham rules.
  task automatic gen_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, err, e2, sx, sy, x, y;
    lx.delete();
    ly.delete();
    dx = x1 > x0 ? x1 - x0 : x0 - x1;
    dy = -(y1 > y0 ? y1 - y0 : y0 - y1);
    err = dx + dy;
    sx = x0 < x1 ? 1 : -1;
    sy = y0 < y1 ? 1 : -1;
    x = x0;
    y = y0;
    for (int k = 0; k < 5000; k++) begin
      lx.push_back(x);
      ly.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask
  task automatic add_line(input int t0, input int col, output int n);
    wr_t w;
    n = lx.size();
    for (int k = 0; k < n; k++) begin
      if (lx[k] < W && ly[k] < H) begin
        w.c = t0 + k; w.x = lx[k]; w.y = ly[k]; w.col = col;
        eq.push_back(w);
      end
    end
  endtask
  task automatic expect_clear(input int t0);
    wr_t w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        w.c = t0 + y * W + x; w.x = x; w.y = y; w.col = 0;
        eq.push_back(w);
      end
    horizon = t0 + W * H + 2;
  endtask
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int exp_acc, input string name);
    int n, acc, t;
    n = 0;
    @(negedge CLOCK_50);
    cif.cmd_x0 = CW'(x0); cif.cmd_y0 = CW'(y0); cif.cmd_x1 = CW'(x1); cif.cmd_y1 = CW'(y1);
    cif.cmd_valid = 1'b1;
    while (!cif.cmd_ready && n < 2000) begin @(negedge CLOCK_50); n++; end
    total++;
    if (!cif.cmd_ready) begin
      bad++;
      $display("FAIL %s accept: cmd_ready=0 after %0d cycles, required 1", name, n);
      cif.cmd_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(negedge CLOCK_50);
    cif.cmd_valid = 1'b0;
    if (exp_acc >= 0) begin
      total++;
      if (acc !== exp_acc) begin bad++; $display("FAIL %s accept edge: got %0d, required %0d", name, acc, exp_acc); end
    end
    t = acc;
    if (m_has_prev != 0) begin
      gen_line(mp[0], mp[1], mp[2], mp[3]);
      add_line(t, 0, n);
      t += n + 1;
    end
    gen_line(x0, y0, x1, y1);
    add_line(t, 1, n);
    t += n;
    edq.push_back(t);
    last_done = t;
    horizon = t + 3;
    mp = '{x0, y0, x1, y1};
    m_has_prev = 1;
  endtask
  task automatic wait_ready(input int exp_c, input string name);
    int n;
    n = 0;
    while (!cif.cmd_ready && n < 5000) begin @(negedge CLOCK_50); n++; end
    total++;
    if (!cif.cmd_ready || cyc !== exp_c) begin
      bad++;
      $display("FAIL %s ready rise: ready=%0b at cycle %0d, required 1 at %0d", name, cif.cmd_ready, cyc, exp_c);
    end
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while (cyc < horizon && n < 5000) begin @(negedge CLOCK_50); n++; end
    total++;
    if (wq.size() != eq.size()) begin bad++; $display("FAIL %s write count: got %0d, required %0d", name, wq.size(), eq.size()); end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      total++;
      if (wq[i].c !== eq[i].c || wq[i].x !== eq[i].x || wq[i].y !== eq[i].y || wq[i].col !== eq[i].col) begin
        bad++;
        $display("FAIL %s write %0d: got c%0d (%0d,%0d) col%0d, required c%0d (%0d,%0d) col%0d", name, i,
                 wq[i].c, wq[i].x, wq[i].y, wq[i].col, eq[i].c, eq[i].x, eq[i].y, eq[i].col);
      end
    end
    total++;
    if (dq.size() != edq.size()) begin bad++; $display("FAIL %s done count: got %0d, required %0d", name, dq.size(), edq.size()); end
    for (int i = 0; i < dq.size() && i < edq.size(); i++) begin
      total++;
      if (dq[i] !== edq[i]) begin bad++; $display("FAIL %s done %0d: got cycle %0d, required %0d", name, i, dq[i], edq[i]); end
    end
    wq.delete(); eq.delete(); dq.delete(); edq.delete();
  endtask
  task automatic test_reset();
    int t0;
    reset = 1'b1;
    cif.cmd_valid = 1'b0; cif.clear_req = 1'b0;
    cif.cmd_x0 = '0; cif.cmd_y0 = '0; cif.cmd_x1 = '0; cif.cmd_y1 = '0;
    @(negedge CLOCK_50);
    total++;
    if (fb_write !== 1'b0 || fb_color !== 1'b0 || fb_x !== '0 || fb_y !== '0) begin
      bad++; $display("FAIL reset fb: got w%0b c%0b (%0d,%0d), required w0 c0 (0,0)", fb_write, fb_color, fb_x, fb_y);
    end
    total++;
    if (cif.cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL reset ctl: got ready=%0b busy=%0b done=%0b, required 0 1 0", cif.cmd_ready, busy, done);
    end
    reset = 1'b0;
    t0 = cyc + 1;
    expect_clear(t0);
    wait_ready(t0 + W * H, "clear");
    drain("clear");
  endtask
  task automatic test_lines();
    issue(0, 0, 3, 0, -1, "first");
    drain("first");
    issue(0, 0, 2, 5, -1, "steep");
    drain("steep");
    issue(3, 0, 0, 0, -1, "reversed");
    drain("reversed");
    issue(5, 5, 5, 5, -1, "point");
    drain("point");
    issue(W - 2, 0, W + 1, 0, -1, "clip");
    drain("clip");
  endtask
  task automatic test_back_to_back();
    issue(0, 3, 9, 3, -1, "b2b_a");
    total++;
    if (cif.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b busy: got ready=%0b busy=%0b, required 0 1", cif.cmd_ready, busy);
    end
    issue(9, 3, 2, 8, last_done + 1, "b2b_b");
    drain("b2b");
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      issue($urandom_range(0, W + 3), $urandom_range(0, H + 3), $urandom_range(0, W + 3), $urandom_range(0, H + 3), -1, "random");
    end
    drain("random");
  endtask
  task automatic test_reset_mid();
    int n, t0;
    n = 0;
    issue(0, 0, W - 1, H - 1, -1, "long");
    while (!(fb_write && fb_color) && n < 200) begin @(negedge CLOCK_50); n++; end
    total++;
    if (!(fb_write && fb_color)) begin bad++; $display("FAIL mid draw: no colour-1 write seen, required one"); end
    reset = 1'b1;
    @(negedge CLOCK_50);
    total++;
    if (fb_write !== 1'b0 || fb_x !== '0 || fb_y !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL mid reset: got w%0b (%0d,%0d) busy=%0b, required w0 (0,0) busy=1", fb_write, fb_x, fb_y, busy);
    end
    reset = 1'b0;
    wq.delete(); eq.delete(); dq.delete(); edq.delete();
    m_has_prev = 0;
    t0 = cyc + 1;
    expect_clear(t0);
    wait_ready(t0 + W * H, "mid_clear");
    drain("mid_clear");
    issue(1, 1, 3, 2, -1, "after_reset");
    drain("after_reset");
  endtask
  task automatic test_clear_req();
    int e;
    @(negedge CLOCK_50);
    cif.cmd_x0 = CW'(1); cif.cmd_y0 = CW'(1); cif.cmd_x1 = CW'(4); cif.cmd_y1 = CW'(4);
    cif.clear_req = 1'b1;
    cif.cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cif.clear_req = 1'b0;
    cif.cmd_valid = 1'b0;
    e = cyc;
    total++;
    if (cif.cmd_ready !== 1'b0 || fb_write !== 1'b1 || fb_color !== 1'b0) begin
      bad++; $display("FAIL clear_req start: got ready=%0b w%0b c%0b, required 0 1 0", cif.cmd_ready, fb_write, fb_color);
    end
    m_has_prev = 0;
    expect_clear(e);
    wait_ready(e + W * H, "req_clear");
    drain("req_clear");
    issue(2, 2, 6, 3, -1, "after_clear");
    drain("after_clear");
  endtask
  initial begin
    test_reset();
    test_lines();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_clear_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_sequencer.md
# line_sequencer

Pixel-write sequencer between the line-command source (key/switch logic) and `VGA_framebuffer`. It owns the framebuffer write port, which it drives with one pixel per `CLOCK_50` cycle. It clears the full screen after reset or on request. It accepts line commands over a valid/ready handshake. For each command it erases the previously drawn line (colour 0) and then rasterises the new one (colour 1) with integer Bresenham.

## Interface
Parameters:
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `COORD_W`, 11, coordinate width

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  line command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`  in  `COORD_W` each  line endpoints, unsigned
- `clear_req`  in  1  request a full-screen clear; sampled only in IDLE
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a line command completes
- `fb_x`, `fb_y`  out  `COORD_W` each  pixel address to the framebuffer
- `fb_color`  out  1  pixel colour to the framebuffer
- `fb_write`  out  1  pixel write strobe to the framebuffer

## Operation
- All outputs are registered.
- States:
  - CLEAR: raster scan, x fastest.
  - IDLE.
  - ERASE: redraw the previous line in colour 0.
  - DRAW: draw the new line in colour 1.
- Reset:
  - Enter CLEAR with `fb_x`=`fb_y`=0, `fb_color`=0, `fb_write`=0.
  - `cmd_ready`=0, `busy`=1, `done`=0.
  - `has_prev` cleared.
- CLEAR:
  - Writes every pixel (0..`SCREEN_W`-1, 0..`SCREEN_H`-1) in colour 0, one write per cycle.
  - After (639,479) is written, go to IDLE.
- IDLE:
  - `cmd_ready`=1, `fb_write`=0.
  - `clear_req` takes priority over `cmd_valid` in the same cycle; it goes to CLEAR and clears `has_prev`.
- Command accept (`cmd_valid` && `cmd_ready`):
  - Latch the endpoints.
  - If `has_prev`=1, go to ERASE with the stored previous endpoints; otherwise go to DRAW.
- ERASE completion: go to DRAW with the latched command.
- DRAW completion:
  - Store the command as the previous line and set `has_prev`.
  - Pulse `done`, return to IDLE.
- Bresenham rules:
  - dx=|x1−x0|, dy=−|y1−y0|, err=dx+dy; sx, sy=±1 toward the end point.
  - Each cycle: plot (x,y). If (x,y)=(x1,y1), finish.
  - e2=2·err. If e2≥dy: err+=dy, x+=sx. If e2≤dx: err+=dx, y+=sy.
  - `err`/`e2` are signed, `COORD_W`+2 bits.
  - Both endpoints are inclusive. Pixel count = max(|dx|,|dy|)+1.
  - Reversed endpoints step in the negative direction.
  - A single-point line (x0=x1, y0=y1) yields exactly one write.
- Clipping: a pixel with x≥`SCREEN_W` or y≥`SCREEN_H` is stepped normally but `fb_write`=0 for that cycle.
- `cmd_*` inputs are ignored while `cmd_ready`=0. The source must hold `cmd_valid` until accepted.

## Timing
- Clear: 307200 consecutive write cycles; `cmd_ready` rises the cycle after the last clear write.
- Accept at edge N: the first pixel (ERASE or DRAW) is presented on `fb_*` in cycle N+1. Pixels then follow on consecutive cycles with no gaps.
- ERASE→DRAW: exactly one idle cycle (`fb_write`=0) for stepper reload.
- `done` and `cmd_ready` both assert in the cycle after the last DRAW pixel. The next command can be accepted in that cycle.
- Throughput: latency from accept to `done` = erase pixels + 1 (only if erasing) + draw pixels + 1.
- Reset mid-operation (any state): on the next edge, abandon the line, clear `has_prev`, restart CLEAR at (0,0).
- `clear_req` outside IDLE is ignored; it is not queued.

## Structure
- Package `line_seq_pkg`:
  - State enum `seq_state_t` (CLEAR, IDLE, ERASE, DRAW).
  - Constants `SCREEN_W_DEF`, `SCREEN_H_DEF`, `COORD_W_DEF`.
  - Typedef `coord_t`.
- Sub-module `bresenham_stepper`:
  - Inputs: `start`, endpoints.
  - Outputs: `x`, `y`, `valid`, `last`.
  - One pixel per cycle; loads on `start`.
- The top-level FSM owns the clear counter, the previous-line registers and the output registers.

## Test plan
- Reset held 1 cycle, then released → exactly 307200 `fb_write` cycles with `fb_color`=0. First write (0,0), last (639,479). `cmd_ready` rises the next cycle.
- First command after clear, (0,0)→(3,0) → writes (0,0),(1,0),(2,0),(3,0) colour 1 on consecutive cycles starting accept+1. `done` pulses once, the cycle after (3,0).
- Second command, (0,0)→(2,5) → erase (0,0)..(3,0) colour 0, one gap cycle, then colour 1 writes (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- Reversed command (3,0)→(0,0), and single point (5,5)→(5,5) → writes 3,2,1,0 in order; single point gives exactly one write.
- Clipping and backpressure: line (638,0)→(641,0) → writes only (638,0),(639,0), with 4 stepping cycles. `cmd_valid` asserted mid-DRAW → not accepted until `cmd_ready`.
- Reset asserted mid-DRAW, and `clear_req` with `cmd_valid` together in IDLE → reset: the next write is (0,0) colour 0 and the full 307200-pixel clear follows. Simultaneous `clear_req`/`cmd_valid`: CLEAR wins, the command is not accepted, and no erase occurs afterward.
